// File: rtl/mux_rr_stream_if.sv
// Stream bundle between N producer channels and the single muxed consumer.
// The mux itself uses the slave view; whatever feeds and drains it uses master.
interface mux_rr_stream_if #(
    parameter int size     = 32,
    parameter int channels = 16,
    parameter int sel_w    = 4
) ();

    logic [channels*size-1:0] in_data;
    logic [channels-1:0]      in_valid;
    logic [channels-1:0]      in_ready;
    logic [size-1:0]          out_data;
    logic [sel_w-1:0]         out_chan;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );

endinterface

// File: rtl/mux_rr_stream.sv
// Registered N:1 stream multiplexer.
// A single output register is refilled whenever it is empty or being drained.
// The source is either a directly selected channel or the first valid channel
// found by a round-robin scan that starts just after the last granted one.
module mux_rr_stream #(
    parameter int size     = 32,
    parameter int channels = 16,
    parameter int sel_w    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [sel_w-1:0] select,
    mux_rr_stream_if.slave   bus
);

    localparam int pad_w = 2 ** sel_w;

    logic [size-1:0]  out_data_q, out_data_d;
    logic [sel_w-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [sel_w-1:0] ptr_q, ptr_d;

    logic                load_en;
    logic                direct_found;
    logic                rr_found;
    logic [sel_w-1:0]    rr_idx;
    logic                grant_found;
    logic [sel_w-1:0]    grant_idx;
    logic [size-1:0]     grant_data;
    logic                transfer;
    logic [channels-1:0] in_ready_c;
    logic [pad_w-1:0]    valid_pad;

    // The output register may accept a new word when empty or when it drains this cycle.
    always_comb begin
        load_en = !out_valid_q || bus.out_ready;
    end

    // Direct mode: valid bits are zero-padded to the full select range so that an
    // out-of-range select naturally finds nothing.
    always_comb begin
        valid_pad                = '0;
        valid_pad[channels-1:0]  = bus.in_valid;
        direct_found             = (int'(select) < channels) && valid_pad[select];
    end

    // Round-robin: pick the valid channel with the smallest forward distance from ptr.
    always_comb begin : rr_search
        int best_d;
        int d;
        best_d   = channels;
        d        = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < channels; k++) begin
            d = (k >= int'(ptr_q)) ? (k - int'(ptr_q)) : (k + channels - int'(ptr_q));
            if (bus.in_valid[k] && (d < best_d)) begin
                best_d   = d;
                rr_idx   = sel_w'(k);
                rr_found = 1'b1;
            end
        end
    end

    // Choose the candidate for the active mode and gate it with reset and load_en.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_found = rr_found;
            grant_idx   = rr_idx;
        end else begin
            grant_found = direct_found;
            grant_idx   = select;
        end
        transfer = grant_found && load_en && !reset;
    end

    // One-hot ready toward the granted channel and data steering from it.
    always_comb begin
        in_ready_c = '0;
        grant_data = '0;
        for (int k = 0; k < channels; k++) begin
            if (grant_idx == sel_w'(k)) begin
                in_ready_c[k] = transfer;
                grant_data    = bus.in_data[k*size +: size];
            end
        end
    end

    // Next-state for the output register and scan pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = transfer;
            if (transfer) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                ptr_d      = (int'(grant_idx) == channels - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // State registers; reset discards any held word and restarts the scan at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter: size, 32, data width per channel in bits.
REQ-002 Parameter: channels, 16, number of input channels; legal range 2..16.
REQ-003 Parameter: sel_w, 4, width of select and out_chan; 2**sel_w SHALL be >= channels.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_data  input  channels*size  flattened channel data; channel k occupies bits [k*size +: size].
REQ-007 Port: in_valid  input  channels  per-channel valid.
REQ-008 Port: in_ready  output  channels  per-channel ready; at most one bit high per cycle.
REQ-009 Port: mode  input  1  0 = direct select, 1 = round-robin scan.
REQ-010 Port: select  input  sel_w  channel index used in direct mode; ignored in round-robin mode.
REQ-011 Port: out_data  output  size  registered selected data.
REQ-012 Port: out_chan  output  sel_w  registered index of the channel that produced out_data.
REQ-013 Port: out_valid  output  1  output register holds a word.
REQ-014 Port: out_ready  input  1  downstream accepts out_data when high together with out_valid.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready); grants SHALL occur only when load_en = 1.
REQ-016 Direct mode: the granted channel SHALL be select when select < channels and in_valid[select] = 1; otherwise there is no grant.
REQ-017 Round-robin mode: the granted channel SHALL be the first k with in_valid[k] = 1, searching ptr, ptr+1, ... modulo channels; no grant if no valid bit is set.
REQ-018 in_ready[g] SHALL be 1 combinationally in the cycle of a grant to channel g; all other in_ready bits SHALL be 0.
REQ-019 A transfer on channel g occurs when in_valid[g] && in_ready[g]; on that edge out_data <= channel g data, out_chan <= g, and out_valid <= 1.
REQ-020 When load_en = 1 and there is no grant, out_valid SHALL be cleared to 0; out_data and out_chan SHALL hold their values.
REQ-021 When load_en = 0 (out_valid = 1, out_ready = 0), out_data, out_chan and out_valid SHALL hold their values; in_ready SHALL be all zero.
REQ-022 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-023 Full throughput: with out_ready held at 1, one transfer SHALL be possible every cycle.
REQ-024 Internal pointer ptr (sel_w bits) SHALL update on every transfer, in either mode, to (g+1) mod channels; wrap from channels-1 SHALL give 0.
REQ-025 Changes to mode or select SHALL take effect in the same cycle; no state other than ptr SHALL depend on mode.
REQ-026 Data SHALL pass unmodified; no X or Z SHALL be driven on any output after reset.

Reset
REQ-027 While reset = 1 at a clock edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-028 While reset = 1, in_ready SHALL be all zero regardless of other inputs.
REQ-029 Reset asserted while out_valid = 1 and out_ready = 0 SHALL discard the held word; no transfer SHALL complete in the reset cycle.

Verification
REQ-030 Direct: mode=0, select=5, in_valid=16'h0020, ch5 data=32'hDEAD_BEEF, out_ready=1 -> in_ready=16'h0020; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_chan=5.
REQ-031 Round-robin fairness: mode=1, in_valid=16'hFFFF, out_ready=1, 20 cycles from reset -> out_chan sequence 0,1,...,15,0,1,2,3.
REQ-032 Sparse scan with wrap: mode=1, ptr=14 (after a transfer on ch13), in_valid=16'h0006 -> grant ch1, then ch2, then ptr=3.
REQ-033 Backpressure: out_valid=1 with out_ready=0 for 3 cycles, in_valid=16'h0001 -> in_ready=0 throughout and out_data stable; on out_ready=1, ch0 is granted that cycle.
REQ-034 Out-of-range select (channels=12): mode=0, select=13, in_valid=12'hFFF -> in_ready=0, out_valid falls to 0 on the next edge.
REQ-035 Reset mid-stall: out_valid=1, out_ready=0, reset=1 for one cycle -> out_valid=0, out_data=0, out_chan=0, and the first round-robin grant afterward is the lowest valid channel from 0.
